// File: rtl/systolic_buf_feeder.sv
// Buffer feeder for the systolic MAC array: prefetches one weight set (TOUT words)
// per tile and streams cfg_wout data words per tile, weights running at most one set ahead.
`timescale 1ns/1ps
module systolic_buf_feeder #(
    parameter int TOUT     = 8,
    parameter int LOG2TOUT = 3,
    parameter int DAT_W    = 64,
    parameter int WT_W     = 64,
    parameter int AW       = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [15:0]         cfg_wout,
    input  logic [7:0]          cfg_tiles,
    input  logic [AW-1:0]       cfg_dat_base,
    input  logic [AW-1:0]       cfg_wt_base,
    output logic                busy,
    output logic                done,
    output logic                dat_rd_en,
    output logic [AW-1:0]       dat_rd_addr,
    input  logic [DAT_W-1:0]    dat_rd_data,
    output logic                wt_rd_en,
    output logic [AW-1:0]       wt_rd_addr,
    input  logic [WT_W-1:0]     wt_rd_data,
    output logic                dat_vld,
    output logic [DAT_W-1:0]    dat,
    output logic                Wout_loop_start,
    output logic                Wout_loop_end,
    output logic                wt_vld,
    output logic [WT_W-1:0]     wt,
    output logic [LOG2TOUT-1:0] wt_sel
);
    localparam logic [1:0] W_IDLE    = 2'd0;
    localparam logic [1:0] W_FETCH   = 2'd1;
    localparam logic [1:0] W_WAIT    = 2'd2;
    localparam logic [1:0] D_IDLE    = 2'd0;
    localparam logic [1:0] D_WAIT_WT = 2'd1;
    localparam logic [1:0] D_STREAM  = 2'd2;
    localparam logic [1:0] D_DONE    = 2'd3;

    logic                busy_q, busy_d, done_q, done_d;
    logic [15:0]         wout_q, wout_d;
    logic [7:0]          tiles_q, tiles_d;
    logic [AW-1:0]       dat_base_q, dat_base_d, wt_base_q, wt_base_d;
    logic [1:0]          wst_q, wst_d, dst_q, dst_d;
    logic [7:0]          wset_q, wset_d;
    logic [LOG2TOUT-1:0] wj_q, wj_d;
    logic [8:0]          sets_done_q, sets_done_d;
    logic [7:0]          tile_q, tile_d;
    logic [15:0]         w_q, w_d;
    logic                dat_vld_q, dat_vld_d, wt_vld_q, wt_vld_d;
    logic                loop_start_q, loop_start_d, loop_end_q, loop_end_d;
    logic [LOG2TOUT-1:0] wt_sel_q, wt_sel_d;

    logic accept, cfg_zero, wt_issue, wt_last, dat_issue, w_last, tile_last;
    logic cur_ready, next_ready;
    logic [8:0] tile_x, tile_nx;

    always_comb begin
        accept    = start && !busy_q;
        cfg_zero  = (cfg_wout == 16'd0) || (cfg_tiles == 8'd0);
        wt_issue  = (wst_q == W_FETCH);
        wt_last   = wt_issue && (wj_q == LOG2TOUT'(TOUT - 1));
        dat_issue = (dst_q == D_STREAM);
        w_last    = dat_issue && (w_q == wout_q - 16'd1);
        tile_last = (tile_q == tiles_q - 8'd1);
        tile_x    = {1'b0, tile_q};
        tile_nx   = tile_x + 9'd1;
        // A set counts as ready in the same cycle its last word is issued, so the
        // dependent tile can begin on the very next cycle.
        cur_ready  = (sets_done_q > tile_x)  || (wt_last && ({1'b0, wset_q} == tile_x));
        next_ready = (sets_done_q > tile_nx) || (wt_last && ({1'b0, wset_q} == tile_nx));

        dat_rd_en   = dat_issue;
        dat_rd_addr = dat_issue ? dat_base_q + AW'(w_q) : '0;
        wt_rd_en    = wt_issue;
        wt_rd_addr  = wt_issue ? wt_base_q + AW'({wset_q, wj_q}) : '0;
    end

    always_comb begin
        busy_d     = busy_q;
        done_d     = 1'b0;
        wout_d     = wout_q;
        tiles_d    = tiles_q;
        dat_base_d = dat_base_q;
        wt_base_d  = wt_base_q;
        if (accept) begin
            busy_d     = 1'b1;
            wout_d     = cfg_wout;
            tiles_d    = cfg_tiles;
            dat_base_d = cfg_dat_base;
            wt_base_d  = cfg_wt_base;
        end else if (done_q) begin
            busy_d = 1'b0;
        end

        wst_d       = wst_q;
        wset_d      = wset_q;
        wj_d        = wj_q;
        sets_done_d = sets_done_q + {8'd0, wt_last};
        case (wst_q)
            W_IDLE: if (accept && !cfg_zero) begin
                wst_d       = W_FETCH;
                wset_d      = 8'd0;
                wj_d        = '0;
                sets_done_d = 9'd0;
            end
            W_FETCH: begin
                wj_d = wj_q + 1'b1;
                if (wt_last) begin
                    wj_d  = '0;
                    wst_d = (wset_q == tiles_q - 8'd1) ? W_IDLE : W_WAIT;
                end
            end
            // Only tile wset_q can start while parked here, so its first read releases the next set.
            W_WAIT: if (dat_issue && w_q == 16'd0) begin
                wst_d  = W_FETCH;
                wset_d = wset_q + 8'd1;
            end
            default: wst_d = W_IDLE;
        endcase

        dst_d  = dst_q;
        tile_d = tile_q;
        w_d    = w_q;
        case (dst_q)
            D_IDLE: if (accept) begin
                dst_d  = cfg_zero ? D_DONE : D_WAIT_WT;
                tile_d = 8'd0;
                w_d    = 16'd0;
            end
            D_WAIT_WT: if (cur_ready) dst_d = D_STREAM;
            D_STREAM: begin
                w_d = w_q + 16'd1;
                if (w_last) begin
                    w_d = 16'd0;
                    if (tile_last) begin
                        dst_d = D_DONE;
                    end else begin
                        tile_d = tile_q + 8'd1;
                        dst_d  = next_ready ? D_STREAM : D_WAIT_WT;
                    end
                end
            end
            D_DONE: begin
                dst_d  = D_IDLE;
                done_d = 1'b1;
            end
            default: dst_d = D_IDLE;
        endcase

        dat_vld_d    = dat_issue;
        loop_start_d = dat_issue && (w_q == 16'd0);
        loop_end_d   = w_last;
        wt_vld_d     = wt_issue;
        wt_sel_d     = wt_issue ? wj_q : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            wout_q       <= 16'd0;
            tiles_q      <= 8'd0;
            dat_base_q   <= '0;
            wt_base_q    <= '0;
            wst_q        <= W_IDLE;
            dst_q        <= D_IDLE;
            wset_q       <= 8'd0;
            wj_q         <= '0;
            sets_done_q  <= 9'd0;
            tile_q       <= 8'd0;
            w_q          <= 16'd0;
            dat_vld_q    <= 1'b0;
            loop_start_q <= 1'b0;
            loop_end_q   <= 1'b0;
            wt_vld_q     <= 1'b0;
            wt_sel_q     <= '0;
        end else begin
            busy_q       <= busy_d;
            done_q       <= done_d;
            wout_q       <= wout_d;
            tiles_q      <= tiles_d;
            dat_base_q   <= dat_base_d;
            wt_base_q    <= wt_base_d;
            wst_q        <= wst_d;
            dst_q        <= dst_d;
            wset_q       <= wset_d;
            wj_q         <= wj_d;
            sets_done_q  <= sets_done_d;
            tile_q       <= tile_d;
            w_q          <= w_d;
            dat_vld_q    <= dat_vld_d;
            loop_start_q <= loop_start_d;
            loop_end_q   <= loop_end_d;
            wt_vld_q     <= wt_vld_d;
            wt_sel_q     <= wt_sel_d;
        end
    end

    // Read data arrives one cycle after issue, aligned with the registered valids.
    assign busy            = busy_q;
    assign done            = done_q;
    assign dat_vld         = dat_vld_q;
    assign dat             = dat_vld_q ? dat_rd_data : '0;
    assign Wout_loop_start = loop_start_q;
    assign Wout_loop_end   = loop_end_q;
    assign wt_vld          = wt_vld_q;
    assign wt              = wt_vld_q ? wt_rd_data : '0;
    assign wt_sel          = wt_sel_q;
endmodule

// File: tb/tb_systolic_buf_feeder.sv
// Self-checking bench for systolic_buf_feeder: a per-job schedule model derived
// from the tile/set ordering rules, checked cycle by cycle against the DUT.
`timescale 1ns/1ps
module tb_systolic_buf_feeder;
    localparam int TOUT = 8;

    logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0;
    logic [15:0] cfg_wout = '0;
    logic [7:0]  cfg_tiles = '0;
    logic [15:0] cfg_dat_base = '0, cfg_wt_base = '0;
    logic        busy, done, dat_rd_en, wt_rd_en, dat_vld, wt_vld;
    logic        Wout_loop_start, Wout_loop_end;
    logic [15:0] dat_rd_addr, wt_rd_addr;
    logic [63:0] dat_rd_data = '0, wt_rd_data = '0, dat, wt;
    logic [2:0]  wt_sel;
    int checks = 0, errors = 0;

    systolic_buf_feeder dut (
        .clk(clk), .rst_n(rst_n), .start(start), .cfg_wout(cfg_wout), .cfg_tiles(cfg_tiles),
        .cfg_dat_base(cfg_dat_base), .cfg_wt_base(cfg_wt_base), .busy(busy), .done(done),
        .dat_rd_en(dat_rd_en), .dat_rd_addr(dat_rd_addr), .dat_rd_data(dat_rd_data),
        .wt_rd_en(wt_rd_en), .wt_rd_addr(wt_rd_addr), .wt_rd_data(wt_rd_data),
        .dat_vld(dat_vld), .dat(dat), .Wout_loop_start(Wout_loop_start),
        .Wout_loop_end(Wout_loop_end), .wt_vld(wt_vld), .wt(wt), .wt_sel(wt_sel)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] dmem(input logic [15:0] a);
        return {a, ~a, a ^ 16'h5A3C, a + 16'h0101};
    endfunction
    function automatic logic [63:0] wmem(input logic [15:0] a);
        return {a ^ 16'hF00F, a, ~a, a + 16'h7777};
    endfunction

    // Buffer models with a fixed one-cycle read latency.
    always @(posedge clk) begin
        if (dat_rd_en) dat_rd_data <= dmem(dat_rd_addr);
        if (wt_rd_en)  wt_rd_data  <= wmem(wt_rd_addr);
    end

    // Runs one job starting in the current cycle (caller sits just after a posedge).
    // busy_start_at >= 0 issues a second, differently configured start at that cycle.
    task automatic run_job(input logic [15:0] wout, input logic [7:0] tiles,
                           input logic [15:0] dbase, input logic [15:0] wbase,
                           input int busy_start_at, input string name);
        int fs[17], fe[17], ts[17], te[17];
        int nt, dn, s;
        logic e_wen, e_wvld, e_den, e_dvld, e_ls, e_le, e_done, e_busy;
        logic [15:0] e_waddr, e_daddr, a;
        logic [2:0]  e_wsel;
        logic [63:0] e_wt, e_dat;
        nt = (wout == 0) ? 0 : int'(tiles);
        dn = 2;
        if (nt > 0) begin
            fs[0] = 1;
            for (int k = 0; k < nt; k++) begin
                fe[k] = fs[k] + TOUT - 1;
                ts[k] = fe[k] + 1;
                if (k > 0 && te[k-1] + 1 > ts[k]) ts[k] = te[k-1] + 1;
                te[k] = ts[k] + int'(wout) - 1;
                fs[k+1] = ts[k] + 1;
            end
            dn = te[nt-1] + 2;
        end
        start = 1'b1; cfg_wout = wout; cfg_tiles = tiles;
        cfg_dat_base = dbase; cfg_wt_base = wbase;
        for (int t = 0; t <= dn + 3; t++) begin
            @(negedge clk);
            e_wen = 0; e_wvld = 0; e_den = 0; e_dvld = 0; e_ls = 0; e_le = 0;
            e_waddr = '0; e_daddr = '0; e_wsel = '0; e_wt = '0; e_dat = '0;
            for (int k = 0; k < nt; k++) begin
                if (t >= fs[k] && t <= fe[k]) begin
                    e_wen = 1; e_waddr = wbase + 16'(k * TOUT + t - fs[k]);
                end
                if (t - 1 >= fs[k] && t - 1 <= fe[k]) begin
                    s = t - 1 - fs[k];
                    e_wvld = 1; e_wsel = 3'(s);
                    a = wbase + 16'(k * TOUT + s); e_wt = wmem(a);
                end
                if (t >= ts[k] && t <= te[k]) begin
                    e_den = 1; e_daddr = dbase + 16'(t - ts[k]);
                end
                if (t - 1 >= ts[k] && t - 1 <= te[k]) begin
                    e_dvld = 1; e_ls = (t - 1 == ts[k]); e_le = (t - 1 == te[k]);
                    a = dbase + 16'(t - 1 - ts[k]); e_dat = dmem(a);
                end
            end
            e_done = (t == dn);
            e_busy = (t >= 1 && t <= dn);
            checks++;
            if ({wt_rd_en, wt_rd_en ? wt_rd_addr : 16'h0} !== {e_wen, e_waddr}) begin
                errors++;
                $display("FAIL %s wt_rd cyc %0d: got en=%b addr=%h want en=%b addr=%h",
                         name, t, wt_rd_en, wt_rd_addr, e_wen, e_waddr);
            end
            checks++;
            if ({dat_rd_en, dat_rd_en ? dat_rd_addr : 16'h0} !== {e_den, e_daddr}) begin
                errors++;
                $display("FAIL %s dat_rd cyc %0d: got en=%b addr=%h want en=%b addr=%h",
                         name, t, dat_rd_en, dat_rd_addr, e_den, e_daddr);
            end
            checks++;
            if ({wt_vld, wt_vld ? wt_sel : 3'd0} !== {e_wvld, e_wsel} ||
                (e_wvld && wt !== e_wt)) begin
                errors++;
                $display("FAIL %s wt_out cyc %0d: got vld=%b sel=%0d wt=%h want vld=%b sel=%0d wt=%h",
                         name, t, wt_vld, wt_sel, wt, e_wvld, e_wsel, e_wt);
            end
            checks++;
            if ({dat_vld, Wout_loop_start, Wout_loop_end} !== {e_dvld, e_ls, e_le} ||
                (e_dvld && dat !== e_dat)) begin
                errors++;
                $display("FAIL %s dat_out cyc %0d: got vld=%b ls=%b le=%b dat=%h want vld=%b ls=%b le=%b dat=%h",
                         name, t, dat_vld, Wout_loop_start, Wout_loop_end, dat,
                         e_dvld, e_ls, e_le, e_dat);
            end
            checks++;
            if ({busy, done} !== {e_busy, e_done}) begin
                errors++;
                $display("FAIL %s busy_done cyc %0d: got busy=%b done=%b want busy=%b done=%b",
                         name, t, busy, done, e_busy, e_done);
            end
            @(posedge clk); #1;
            // Config is scrambled whenever start is low; it must only be sampled on acceptance.
            start = (t + 1 == busy_start_at);
            cfg_wout = 16'($urandom_range(1, 40));
            cfg_tiles = 8'($urandom_range(0, 5));
            cfg_dat_base = 16'($urandom); cfg_wt_base = 16'($urandom);
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({busy, done, dat_rd_en, wt_rd_en, dat_vld, wt_vld, Wout_loop_start, Wout_loop_end,
             dat, wt, wt_sel} !== '0) begin
            errors++;
            $display("FAIL reset_state: got busy=%b done=%b den=%b wen=%b dv=%b wv=%b want all 0",
                     busy, done, dat_rd_en, wt_rd_en, dat_vld, wt_vld);
        end
        @(posedge clk); #1; rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if ({busy, done, dat_rd_en, wt_rd_en, dat_vld, wt_vld} !== 6'b0) begin
                errors++;
                $display("FAIL idle_after_reset cyc %0d: got %b want 000000", i,
                         {busy, done, dat_rd_en, wt_rd_en, dat_vld, wt_vld});
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_basic();      run_job(16'd16, 8'd2, 16'h0100, 16'h0400, -1, "basic"); endtask
    task automatic test_short_tile(); run_job(16'd3,  8'd2, 16'h0020, 16'h0200, -1, "short_tile"); endtask
    task automatic test_single();     run_job(16'd1,  8'd1, 16'h1234, 16'h4321, -1, "single"); endtask
    task automatic test_zero();
        run_job(16'd5, 8'd0, 16'h0000, 16'h0000, -1, "zero_tiles");
        run_job(16'd0, 8'd3, 16'h0000, 16'h0000, -1, "zero_wout");
    endtask
    task automatic test_busy_start(); run_job(16'd16, 8'd2, 16'h0100, 16'h0400, 7, "busy_start"); endtask
    task automatic test_addr_wrap();  run_job(16'd4, 8'd2, 16'hFFFE, 16'hFFF4, -1, "addr_wrap"); endtask

    task automatic test_reset_midjob();
        start = 1'b1; cfg_wout = 16'd16; cfg_tiles = 8'd2;
        cfg_dat_base = 16'h0100; cfg_wt_base = 16'h0400;
        @(posedge clk); #1; start = 1'b0;
        repeat (14) @(posedge clk);
        #1;
        checks++;
        if (!(busy && dat_rd_en)) begin
            errors++;
            $display("FAIL midjob_active: got busy=%b den=%b want 1 1", busy, dat_rd_en);
        end
        rst_n = 1'b0; #1;
        checks++;
        if ({busy, done, dat_rd_en, wt_rd_en, dat_vld, wt_vld, Wout_loop_start, Wout_loop_end,
             dat, wt, wt_sel, dat_rd_addr, wt_rd_addr} !== '0) begin
            errors++;
            $display("FAIL async_reset: got busy=%b den=%b wen=%b dv=%b wv=%b want all 0",
                     busy, dat_rd_en, wt_rd_en, dat_vld, wt_vld);
        end
        repeat (2) @(posedge clk);
        #1; rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if ({busy, done, dat_rd_en, wt_rd_en, dat_vld, wt_vld} !== 6'b0) begin
                errors++;
                $display("FAIL no_traffic_after_reset cyc %0d: got %b want 000000", i,
                         {busy, done, dat_rd_en, wt_rd_en, dat_vld, wt_vld});
            end
        end
        @(posedge clk); #1;
        run_job(16'd16, 8'd2, 16'h0100, 16'h0400, -1, "after_reset");
    endtask

    task automatic test_random();
        for (int n = 0; n < 8; n++)
            run_job(16'($urandom_range(1, 20)), 8'($urandom_range(1, 4)),
                    16'($urandom), 16'($urandom), -1, "random");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_short_tile();
        test_single();
        test_zero();
        test_busy_start();
        test_addr_wrap();
        test_reset_midjob();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/systolic_buf_feeder.md
SYSTOLIC_BUF_FEEDER -- requirements
Module: systolic_buf_feeder

Interface
REQ-001 Parameters SHALL be: TOUT, 8, columns/weight words per set; LOG2TOUT, 3, log2(TOUT); DAT_W, 64, data word width (base_Tin*MAX_DAT_DW); WT_W, 64, weight word width (base_Tin*MAX_WT_DW); AW, 16, buffer address width.
REQ-002 clk  input  1  clock.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  job start pulse; cfg_* sampled on the same edge.
REQ-005 cfg_wout  input  16  data words per tile (Wout loop length).
REQ-006 cfg_tiles  input  8  weight sets (tiles) per job.
REQ-007 cfg_dat_base  input  AW  data buffer base address; cfg_wt_base  input  AW  weight buffer base address.
REQ-008 busy  output  1  job in progress; done  output  1  one-cycle job-complete pulse.
REQ-009 dat_rd_en  output  1 / dat_rd_addr  output  AW / dat_rd_data  input  DAT_W  data buffer read port, fixed 1-cycle read latency.
REQ-010 wt_rd_en  output  1 / wt_rd_addr  output  AW / wt_rd_data  input  WT_W  weight buffer read port, fixed 1-cycle read latency.
REQ-011 dat_vld  output  1 / dat  output  DAT_W / Wout_loop_start  output  1 / Wout_loop_end  output  1  data stream to systolic MAC control.
REQ-012 wt_vld  output  1 / wt  output  WT_W / wt_sel  output  LOG2TOUT  weight stream to systolic MAC control.

Function
REQ-013 dat SHALL equal dat_rd_data and wt SHALL equal wt_rd_data; dat_vld, wt_vld, wt_sel, Wout_loop_start, Wout_loop_end SHALL be the issue-side signals registered one cycle.
REQ-014 Start SHALL be accepted only when busy=0; start while busy SHALL be ignored.
REQ-015 Weight fetcher FSM: W_IDLE, W_FETCH, W_WAIT; in W_FETCH it SHALL issue TOUT consecutive reads, addr cfg_wt_base + k*TOUT + j, wt_sel=j, j=0..TOUT-1, for tile k.
REQ-016 Set 0 fetch SHALL begin the cycle after start acceptance.
REQ-017 Set k+1 fetch SHALL begin the cycle after the first data read of tile k is issued (wt_sel=0 never coincides with Wout_loop_start; at most one set ahead); no set fetched past cfg_tiles-1.
REQ-018 Data streamer FSM: D_IDLE, D_WAIT_WT, D_STREAM, D_DONE.
REQ-019 D_WAIT_WT: tile k streaming SHALL begin the cycle after the read of set k, wt_sel=TOUT-1, is issued, or immediately if already issued.
REQ-020 D_STREAM: cfg_wout consecutive reads, addr cfg_dat_base + w, w=0..cfg_wout-1, for every tile; no gaps within a tile.
REQ-021 Wout_loop_start SHALL mark w=0, Wout_loop_end SHALL mark w=cfg_wout-1; both high together when cfg_wout=1.
REQ-022 Tile k+1 SHALL start the cycle after tile k's last read when set k+1 is complete; otherwise D_WAIT_WT.
REQ-023 done SHALL pulse the cycle after the final Wout_loop_end; busy SHALL be high from the cycle after start acceptance through the done cycle.
REQ-024 cfg_wout=0 or cfg_tiles=0: no buffer reads, no stream outputs, done pulses 2 cycles after start.
REQ-025 Address arithmetic SHALL wrap modulo 2^AW.

Reset
REQ-026 On rst_n low, all outputs SHALL be 0, both FSMs SHALL go idle, and counters SHALL clear, immediately and asynchronously, including mid-job.
REQ-027 After reset release no traffic SHALL occur until a new start.

Verification
REQ-028 TOUT=8, wout=16, tiles=2, start at cycle 0 -> wt_vld cycles 2-9, sel 0..7; dat_vld 10-25, start@10, end@25; set-1 wt_vld 11-18; tile 1 dat_vld 26-41, end@41; done@42.
REQ-029 wout=3, tiles=2 -> tile 0 dat_vld 10-12; set-1 wt_vld 11-18; tile 1 dat_vld 19-21, Wout_loop_start@19; done@22.
REQ-030 wout=1, tiles=1 -> single dat_vld@10 with Wout_loop_start=Wout_loop_end=1; done@11.
REQ-031 tiles=0 -> no reads, done@2; second start during busy job -> ignored, same timing as REQ-028.
REQ-032 rst_n low at cycle 15 of REQ-028 -> all outputs 0 at once; fresh start after release reproduces REQ-028 timing.
REQ-033 cfg_dat_base=0xFFFE, wout=4 -> dat_rd_addr FFFE, FFFF, 0000, 0001.
